mux_rr_arbiter: RTL and testbench

//   Round-robin arbiter sharing the 4-to-1 mux datapath between four requesters.

---
 rtl/mux_rr_arbiter_pkg.sv | 18 +
 rtl/mux_rr_arbiter_rr_pick4.sv | 48 ++++
 rtl/mux_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants and types for the round-robin mux arbiter.
// Four requesters, 2-bit select, two-state grant FSM.
package mux_rr_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  typedef logic [N_REQ-1:0] req_t;
  typedef logic [SEL_W-1:0] sel_t;

  function automatic req_t onehot(input sel_t idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick4.sv
// Combinational rotating-priority picker: searches last+1, last+2, last+3, last
// among requests not excluded by mask.
module rr_pick4
  import mux_rr_arbiter_pkg::*;
(
  input  logic [3:0] req,
  input  logic [3:0] mask,
  input  logic [1:0] last,
  output logic       found,
  output logic [1:0] idx
);

  logic [3:0] cand_s;
  logic [3:0] rot_s;
  logic [1:0] pos_s;
  logic [1:0] off_s;

  assign cand_s = req & ~mask;

  // Rotate candidates so bit 0 is the highest-priority position (last+1).
  always_comb begin
    rot_s = 4'b0000;
    pos_s = 2'd0;
    for (int j = 0; j < 4; j++) begin
      pos_s    = last + 2'(j) + 2'd1;
      rot_s[j] = cand_s[pos_s];
    end
  end

  // First set bit of the rotated vector gives the offset from last+1.
  always_comb begin
    found = 1'b1;
    off_s = 2'd0;
    casez (rot_s)
      4'b???1: off_s = 2'd0;
      4'b??10: off_s = 2'd1;
      4'b?100: off_s = 2'd2;
      4'b1000: off_s = 2'd3;
      default: begin
        found = 1'b0;
        off_s = 2'd0;
      end
    endcase
  end

  assign idx = last + 2'd1 + off_s;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the 4-to-1 mux select: registered one-hot grant,
// matching select, busy flag, and an optional time-slice quantum.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int QUANTUM = 8,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy
);

  // With no quantum the counter simply saturates at all-ones.
  localparam int unsigned QMAX = (QUANTUM == 0) ? ((1 << CNT_W) - 1) : (QUANTUM - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(QMAX);

  logic [0:0]       state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       sel_q,   sel_d;
  logic             busy_q,  busy_d;
  logic [1:0]       last_q,  last_d;
  logic [CNT_W-1:0] hold_q,  hold_d;

  logic [3:0] mask_s;
  logic       found_s;
  logic [1:0] idx_s;
  logic       expire_s;
  logic       take_s;

  // The current owner is excluded so a hand-off always moves to someone else.
  assign mask_s   = (state_q == ST_GRANT) ? grant_q : 4'b0000;
  assign expire_s = (QUANTUM != 0) && (hold_q == HOLD_MAX);

  rr_pick4 u_pick (
    .req   (req),
    .mask  (mask_s),
    .last  (last_q),
    .found (found_s),
    .idx   (idx_s)
  );

  // Next-state logic: idle/grant transitions, hand-off and quantum preemption.
  always_comb begin
    take_s  = 1'b0;
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    last_d  = last_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          take_s = 1'b1;
        end else begin
          grant_d = 4'b0000;
          busy_d  = 1'b0;
        end
      end
      ST_GRANT: begin
        if (!req[sel_q]) begin
          if (found_s) begin
            take_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
            grant_d = 4'b0000;
            busy_d  = 1'b0;
            hold_d  = {CNT_W{1'b0}};
          end
        end else if (expire_s) begin
          if (found_s) begin
            take_s = 1'b1;
          end else begin
            hold_d = {CNT_W{1'b0}};
          end
        end else begin
          hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 4'b0000;
        busy_d  = 1'b0;
        hold_d  = {CNT_W{1'b0}};
      end
    endcase
    state_d = take_s ? ST_GRANT          : state_d;
    grant_d = take_s ? onehot(idx_s)     : grant_d;
    sel_d   = take_s ? idx_s             : sel_d;
    last_d  = take_s ? idx_s             : last_d;
    busy_d  = take_s ? 1'b1              : busy_d;
    hold_d  = take_s ? {CNT_W{1'b0}}     : hold_d;
  end

  // State and output registers; last=3 on reset so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= 4'b0000;
      sel_q   <= 2'd0;
      busy_q  <= 1'b0;
      last_q  <= 2'd3;
      hold_q  <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter (QUANTUM=4): directed vector table,
// hand-written multi-cycle sequences and randomized traffic against a model.
module tb_mux_rr_arbiter;

  localparam int Q = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner index (-1 = idle), cycles owned so far, pointer.
  int m_owner = -1;
  int m_cnt   = 0;
  int m_last  = 3;
  int m_sel   = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
  } vec_t;

  vec_t tbl[16];

  mux_rr_arbiter #(.QUANTUM(Q), .CNT_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .grant (grant),
    .sel   (sel),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] r, input int last, input int excl);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (last + k) % 4;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model_update(input logic r, input logic [3:0] q);
    int w;
    if (r) begin
      m_owner = -1; m_cnt = 0; m_last = 3; m_sel = 0;
    end else if (m_owner < 0) begin
      w = pick(q, m_last, -1);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_sel = w; m_cnt = 1;
      end
    end else begin
      w = pick(q, m_last, m_owner);
      if (!q[m_owner] || (m_cnt == Q && w >= 0)) begin
        if (w >= 0) begin
          m_owner = w; m_last = w; m_sel = w; m_cnt = 1;
        end else begin
          m_owner = -1; m_cnt = 0;
        end
      end else if (m_cnt == Q) begin
        m_cnt = 1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic step(input logic r, input logic [3:0] q);
    rst = r;
    req = q;
    @(posedge clk);
    model_update(r, q);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [3:0] eg, input logic [1:0] es,
                     input logic eb);
    n_checks++;
    if (grant !== eg || sel !== es || busy !== eb) begin
      n_fail++;
      $display("FAIL %s: got grant=%b sel=%0d busy=%b, expected grant=%b sel=%0d busy=%b",
               name, grant, sel, busy, eg, es, eb);
    end
  endtask

  task automatic chk_model(input string name);
    logic [3:0] eg;
    eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    chk(name, eg, 2'(m_sel), m_owner >= 0);
  endtask

  initial begin
    logic [3:0] rq;

    tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1};
    tbl[3]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
    for (int i = 4; i <= 8; i++) tbl[i] = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
    tbl[9]  = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0};
    tbl[10] = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0};
    tbl[11] = '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1};
    tbl[12] = '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1};
    tbl[13] = '{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1};
    tbl[14] = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1};
    tbl[15] = '{1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0};

    // Reset, single requester, release to idle, owner hand-off.
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].rst, tbl[i].req);
      chk($sformatf("vec%0d", i), tbl[i].grant, tbl[i].sel, tbl[i].busy);
    end

    // Full contention: each owner keeps the path exactly Q cycles, no gaps.
    step(1'b1, 4'b0000);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 4'b1111);
      chk($sformatf("contend%0d", k), 4'b0001 << ((k / Q) % 4), 2'((k / Q) % 4), 1'b1);
    end

    // Sole owner: quantum expiry with nobody waiting keeps the grant.
    step(1'b1, 4'b0000);
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 4'b0001);
      chk($sformatf("sole%0d", k), 4'b0001, 2'd0, 1'b1);
      n_checks++;
      if (dut.hold_q !== 8'(k % Q)) begin
        n_fail++;
        $display("FAIL sole_hold%0d: got hold=%0d expected %0d", k, dut.hold_q, k % Q);
      end
    end

    // Reset mid-grant clears everything and restores the pointer.
    step(1'b1, 4'b0000);
    step(1'b0, 4'b1000);
    chk("midrst_pre", 4'b1000, 2'd3, 1'b1);
    step(1'b1, 4'b1111);
    chk("midrst_rst", 4'b0000, 2'd0, 1'b0);
    step(1'b0, 4'b1111);
    chk("midrst_post", 4'b0001, 2'd0, 1'b1);

    // Randomized traffic: requesters hold until granted, owners release randomly.
    step(1'b1, 4'b0000);
    chk_model("rand_rst");
    rq = 4'b0000;
    for (int c = 0; c < 600; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!rq[r]) begin
          if ($urandom_range(3) == 0) rq[r] = 1'b1;
        end else if (m_owner == r) begin
          if ($urandom_range(4) == 0) rq[r] = 1'b0;
        end
      end
      if ($urandom_range(149) == 0) begin
        step(1'b1, rq);
      end else begin
        step(1'b0, rq);
      end
      chk_model($sformatf("rand%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
